// File: rtl/controller.sv
// Instruction decoder for the 5-stage MIPS pipeline: combinational datapath controls and hazard
// timing, plus a sticky flag that remembers any unsupported instruction seen since reset.
module controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruc,
    output logic [3:0]  AluCtrl,
    output logic        AluSrc,
    output logic        ExtOp,
    output logic        RegWrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic        MemWrite,
    output logic        Branch,
    output logic        Jump,
    output logic        JumpReg,
    output logic [1:0]  Tuse_rs,
    output logic [1:0]  Tuse_rt,
    output logic [1:0]  Tnew_E,
    output logic        illegal,
    output logic        illegal_seen
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_LUI  = 4'd3;

    localparam logic [1:0] T_UNUSED = 2'd3;

    logic [5:0] op;
    logic [5:0] funct;

    assign op    = instruc[31:26];
    assign funct = instruc[5:0];

    always_comb begin
        AluCtrl  = ALU_ADD;
        AluSrc   = 1'b0;
        ExtOp    = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 2'd0;
        MemtoReg = 2'd0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        JumpReg  = 1'b0;
        Tuse_rs  = T_UNUSED;
        Tuse_rt  = T_UNUSED;
        Tnew_E   = 2'd0;
        illegal  = 1'b0;

        case (op)
            OP_RTYPE: begin
                // The all-zero word is nop; any other funct-0 encoding (e.g. a real sll) is rejected.
                if (instruc != 32'd0) begin
                    case (funct)
                        FN_ADDU: begin
                            AluCtrl  = ALU_ADD;
                            RegWrite = 1'b1;
                            RegDst   = 2'd1;
                            Tuse_rs  = 2'd1;
                            Tuse_rt  = 2'd1;
                            Tnew_E   = 2'd1;
                        end
                        FN_SUBU: begin
                            AluCtrl  = ALU_SUB;
                            RegWrite = 1'b1;
                            RegDst   = 2'd1;
                            Tuse_rs  = 2'd1;
                            Tuse_rt  = 2'd1;
                            Tnew_E   = 2'd1;
                        end
                        FN_JR: begin
                            JumpReg  = 1'b1;
                            Tuse_rs  = 2'd0;
                        end
                        default: illegal = 1'b1;
                    endcase
                end
            end
            OP_ORI: begin
                AluCtrl  = ALU_OR;
                AluSrc   = 1'b1;
                RegWrite = 1'b1;
                Tuse_rs  = 2'd1;
                Tnew_E   = 2'd1;
            end
            OP_LW: begin
                AluSrc   = 1'b1;
                ExtOp    = 1'b1;
                RegWrite = 1'b1;
                MemtoReg = 2'd1;
                Tuse_rs  = 2'd1;
                Tnew_E   = 2'd2;
            end
            OP_SW: begin
                AluSrc   = 1'b1;
                ExtOp    = 1'b1;
                MemWrite = 1'b1;
                Tuse_rs  = 2'd1;
                Tuse_rt  = 2'd2;
            end
            OP_BEQ: begin
                Branch   = 1'b1;
                AluCtrl  = ALU_SUB;
                ExtOp    = 1'b1;
                Tuse_rs  = 2'd0;
                Tuse_rt  = 2'd0;
            end
            OP_LUI: begin
                AluCtrl  = ALU_LUI;
                AluSrc   = 1'b1;
                RegWrite = 1'b1;
                Tnew_E   = 2'd1;
            end
            OP_J: begin
                Jump     = 1'b1;
            end
            OP_JAL: begin
                // Link value PC+8 is already available, so it forwards as soon as it reaches E.
                Jump     = 1'b1;
                RegWrite = 1'b1;
                RegDst   = 2'd2;
                MemtoReg = 2'd2;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_seen <= 1'b0;
        end else if (illegal) begin
            illegal_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: table-driven decode vectors through an expected-value
// queue, then hand-written sequences for the sticky illegal_seen flag around reset.
module tb_controller;

    typedef struct packed {
        logic [3:0] alu;
        logic       src;
        logic       ext;
        logic       rw;
        logic [1:0] dst;
        logic [1:0] m2r;
        logic       mw;
        logic       br;
        logic       j;
        logic       jr;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [1:0] tnew;
        logic       ill;
    } ctl_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        ctl_t        exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruc;
    logic [3:0]  AluCtrl;
    logic        AluSrc;
    logic        ExtOp;
    logic        RegWrite;
    logic [1:0]  RegDst;
    logic [1:0]  MemtoReg;
    logic        MemWrite;
    logic        Branch;
    logic        Jump;
    logic        JumpReg;
    logic [1:0]  Tuse_rs;
    logic [1:0]  Tuse_rt;
    logic [1:0]  Tnew_E;
    logic        illegal;
    logic        illegal_seen;

    int n_checks = 0;
    int n_fail   = 0;

    ctl_t exp_q[$];
    vec_t vecs[$];

    controller dut (
        .clk(clk),
        .rst_n(rst_n),
        .instruc(instruc),
        .AluCtrl(AluCtrl),
        .AluSrc(AluSrc),
        .ExtOp(ExtOp),
        .RegWrite(RegWrite),
        .RegDst(RegDst),
        .MemtoReg(MemtoReg),
        .MemWrite(MemWrite),
        .Branch(Branch),
        .Jump(Jump),
        .JumpReg(JumpReg),
        .Tuse_rs(Tuse_rs),
        .Tuse_rt(Tuse_rt),
        .Tnew_E(Tnew_E),
        .illegal(illegal),
        .illegal_seen(illegal_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    function automatic ctl_t mk(input logic [3:0] alu, input logic src, input logic ext,
                                input logic rw, input logic [1:0] dst, input logic [1:0] m2r,
                                input logic mw, input logic br, input logic j, input logic jr,
                                input logic [1:0] rs, input logic [1:0] rt,
                                input logic [1:0] tnew, input logic ill);
        ctl_t c;
        c.alu = alu; c.src = src; c.ext = ext; c.rw = rw; c.dst = dst; c.m2r = m2r;
        c.mw = mw; c.br = br; c.j = j; c.jr = jr; c.rs = rs; c.rt = rt; c.tnew = tnew;
        c.ill = ill;
        return c;
    endfunction

    function automatic vec_t v(input string name, input logic [31:0] ins, input ctl_t exp);
        vec_t r;
        r.name = name; r.ins = ins; r.exp = exp;
        return r;
    endfunction

    task automatic check_decode(input string name);
        ctl_t act;
        ctl_t exp;
        act = '{AluCtrl, AluSrc, ExtOp, RegWrite, RegDst, MemtoReg, MemWrite, Branch,
                Jump, JumpReg, Tuse_rs, Tuse_rt, Tnew_E, illegal};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
            return;
        end
        exp = exp_q.pop_front();
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h (alu=%0d src=%b ext=%b rw=%b dst=%0d m2r=%0d mw=%b br=%b j=%b jr=%b rs=%0d rt=%0d tnew=%0d ill=%b) expected %h",
                     name, act, act.alu, act.src, act.ext, act.rw, act.dst, act.m2r, act.mw,
                     act.br, act.j, act.jr, act.rs, act.rt, act.tnew, act.ill, exp);
        end
    endtask

    task automatic check_seen(input string name, input logic exp);
        n_checks++;
        if (illegal_seen !== exp) begin
            n_fail++;
            $display("FAIL %s: illegal_seen got %b expected %b", name, illegal_seen, exp);
        end
    endtask

    initial begin
        //              alu src ext rw dst m2r mw br j jr rs rt tnew ill
        vecs.push_back(v("addu",     32'h00221821, mk(4'd0,0,0,1,2'd1,2'd0,0,0,0,0,2'd1,2'd1,2'd1,0)));
        vecs.push_back(v("subu",     32'h00221823, mk(4'd1,0,0,1,2'd1,2'd0,0,0,0,0,2'd1,2'd1,2'd1,0)));
        vecs.push_back(v("ori",      32'h3401FFFF, mk(4'd2,1,0,1,2'd0,2'd0,0,0,0,0,2'd1,2'd3,2'd1,0)));
        vecs.push_back(v("lui",      32'h3C011234, mk(4'd3,1,0,1,2'd0,2'd0,0,0,0,0,2'd3,2'd3,2'd1,0)));
        vecs.push_back(v("lw",       32'h8C220004, mk(4'd0,1,1,1,2'd0,2'd1,0,0,0,0,2'd1,2'd3,2'd2,0)));
        vecs.push_back(v("sw",       32'hAC220004, mk(4'd0,1,1,0,2'd0,2'd0,1,0,0,0,2'd1,2'd2,2'd0,0)));
        vecs.push_back(v("beq",      32'h10220003, mk(4'd1,0,1,0,2'd0,2'd0,0,1,0,0,2'd0,2'd0,2'd0,0)));
        vecs.push_back(v("j",        32'h08000010, mk(4'd0,0,0,0,2'd0,2'd0,0,0,1,0,2'd3,2'd3,2'd0,0)));
        vecs.push_back(v("jal",      32'h0C000010, mk(4'd0,0,0,1,2'd2,2'd2,0,0,1,0,2'd3,2'd3,2'd0,0)));
        vecs.push_back(v("jr_ra",    32'h03E00008, mk(4'd0,0,0,0,2'd0,2'd0,0,0,0,1,2'd0,2'd3,2'd0,0)));
        vecs.push_back(v("nop",      32'h00000000, mk(4'd0,0,0,0,2'd0,2'd0,0,0,0,0,2'd3,2'd3,2'd0,0)));
        vecs.push_back(v("op_3f",    32'hFC000000, mk(4'd0,0,0,0,2'd0,2'd0,0,0,0,0,2'd3,2'd3,2'd0,1)));
        vecs.push_back(v("sll_nz",   32'h00011080, mk(4'd0,0,0,0,2'd0,2'd0,0,0,0,0,2'd3,2'd3,2'd0,1)));
        vecs.push_back(v("add_sgn",  32'h00221820, mk(4'd0,0,0,0,2'd0,2'd0,0,0,0,0,2'd3,2'd3,2'd0,1)));
        vecs.push_back(v("addu_r0",  32'h00220021, mk(4'd0,0,0,1,2'd1,2'd0,0,0,0,0,2'd1,2'd1,2'd1,0)));
        vecs.push_back(v("addi_ill", 32'h20010005, mk(4'd0,0,0,0,2'd0,2'd0,0,0,0,0,2'd3,2'd3,2'd0,1)));
        vecs.push_back(v("lw_fn21",  32'h8C000021, mk(4'd0,1,1,1,2'd0,2'd1,0,0,0,0,2'd1,2'd3,2'd2,0)));

        rst_n   = 1'b0;
        instruc = 32'h00221821;
        #1;
        check_seen("reset_seen", 1'b0);

        // Decode is clock/reset independent: run the table with reset held.
        foreach (vecs[i]) begin
            @(negedge clk);
            instruc = vecs[i].ins;
            exp_q.push_back(vecs[i].exp);
            #1;
            check_decode(vecs[i].name);
        end
        check_seen("seen_held_in_reset", 1'b0);

        // Release with a legal instruction: no set.
        @(negedge clk);
        instruc = 32'h00221821;
        rst_n   = 1'b1;
        @(posedge clk); #1;
        check_seen("legal_no_set", 1'b0);

        @(negedge clk);
        instruc = 32'hFC000000;
        @(posedge clk); #1;
        check_seen("illegal_sets", 1'b1);

        @(negedge clk);
        instruc = 32'h00221821;
        @(posedge clk); #1;
        check_seen("sticky_1", 1'b1);
        @(posedge clk); #1;
        check_seen("sticky_2", 1'b1);

        // Asynchronous clear between edges.
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_seen("async_clear", 1'b0);

        // Illegal word present while reset held, then released: first edge samples it.
        instruc = 32'hFC000000;
        @(posedge clk); #1;
        check_seen("reset_dominates", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_seen("release_no_edge", 1'b0);
        @(posedge clk); #1;
        check_seen("first_edge_samples", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
